// File: rtl/sift_pkg.sv
// Shared definitions for the SIFT keypoint path: tally FSM states and count limits.
package sift_pkg;

  localparam int unsigned KP_CNT_W = 11;
  localparam int unsigned KP_SAT   = (1 << KP_CNT_W) - 1;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    CLOSE,
    UPDATE
  } kp_state_e;

endpackage

// File: rtl/kp_history_avg.sv
// Ring buffer of the last 2^AVG_LOG2 frame counts with a running sum.
// The first load after reset fills every slot so the average starts primed.
module kp_history_avg
  import sift_pkg::*;
#(
  parameter int unsigned CNT_W    = KP_CNT_W,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] count_i,
  output logic [CNT_W-1:0] avg_o
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = CNT_W + AVG_LOG2;

  logic [CNT_W-1:0]    hist_q [DEPTH];
  logic [CNT_W-1:0]    hist_d [DEPTH];
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic                primed_q, primed_d;

  always_comb begin
    hist_d   = hist_q;
    sum_d    = sum_q;
    wr_ptr_d = wr_ptr_q;
    primed_d = primed_q;
    if (load_i) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (!primed_q) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          hist_d[i] = count_i;
        end
        sum_d    = {count_i, {AVG_LOG2{1'b0}}};
        primed_d = 1'b1;
      end else begin
        hist_d[wr_ptr_q] = count_i;
        sum_d = sum_q - {{AVG_LOG2{1'b0}}, hist_q[wr_ptr_q]}
                      + {{AVG_LOG2{1'b0}}, count_i};
      end
    end
  end

  // Average of the post-load sum, so the caller can register it on the load edge.
  assign avg_o = sum_d[SUM_W-1:AVG_LOG2];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        hist_q[i] <= '0;
      end
      sum_q    <= '0;
      wr_ptr_q <= '0;
      primed_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      sum_q    <= sum_d;
      wr_ptr_q <= wr_ptr_d;
      primed_q <= primed_d;
    end
  end

endmodule

// File: rtl/keypoint_tally.sv
// Per-frame keypoint counter with saturation, frame watchdog and a smoothed
// once-per-frame output for the adaptive threshold controller.
module keypoint_tally
  import sift_pkg::*;
#(
  parameter int unsigned CNT_W       = KP_CNT_W,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned TIMEOUT_CYC = 1048576,
  parameter int unsigned INIT_NUM    = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             frame_end,
  input  logic [1:0]       kp_inc,
  output logic [CNT_W-1:0] keypoint_num,
  output logic [CNT_W-1:0] keypoint_raw,
  output logic             num_valid,
  output logic             kp_overflow,
  output logic             frame_timeout,
  output logic             busy
);

  localparam int unsigned      CYC_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CYC_W-1:0] TIMEOUT_V = CYC_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] INIT_V    = CNT_W'(INIT_NUM);

  kp_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] keypoint_num_q, keypoint_num_d;
  logic [CNT_W-1:0] keypoint_raw_q, keypoint_raw_d;
  logic             num_valid_q, num_valid_d;
  logic             kp_overflow_q, kp_overflow_d;
  logic             frame_timeout_q, frame_timeout_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] inc_ext;
  logic [CNT_W:0]   sum_ext;
  logic             sat_hit;
  logic [CNT_W-1:0] count_sat;
  logic [CYC_W-1:0] cyc_inc;
  logic             hist_load;
  logic [CNT_W-1:0] hist_avg;

  // Count plus at most 3 never reaches twice the limit, so the carry flags saturation.
  assign inc_ext   = {{(CNT_W-2){1'b0}}, kp_inc};
  assign sum_ext   = {1'b0, count_q} + {1'b0, inc_ext};
  assign sat_hit   = sum_ext[CNT_W];
  assign count_sat = sat_hit ? '1 : sum_ext[CNT_W-1:0];
  assign cyc_inc   = cyc_q + 1'b1;

  kp_history_avg #(
    .CNT_W    (CNT_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .load_i  (hist_load),
    .count_i (keypoint_raw_q),
    .avg_o   (hist_avg)
  );

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    cyc_d           = cyc_q;
    ovf_d           = ovf_q;
    keypoint_num_d  = keypoint_num_q;
    keypoint_raw_d  = keypoint_raw_q;
    num_valid_d     = 1'b0;
    kp_overflow_d   = kp_overflow_q;
    frame_timeout_d = frame_timeout_q;
    hist_load       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d         = COUNT;
          count_d         = inc_ext;
          cyc_d           = CYC_W'(1);
          ovf_d           = 1'b0;
          frame_timeout_d = 1'b0;
        end
      end
      COUNT: begin
        // Raw/overflow/timeout are registered on the closing edge so they are
        // visible during CLOSE; the history load then happens in CLOSE.
        if (frame_end || (!frame_start && cyc_inc == TIMEOUT_V)) begin
          state_d         = CLOSE;
          count_d         = count_sat;
          keypoint_raw_d  = count_sat;
          kp_overflow_d   = ovf_q | sat_hit;
          frame_timeout_d = !frame_end;
        end else if (frame_start) begin
          count_d         = inc_ext;
          cyc_d           = CYC_W'(1);
          ovf_d           = 1'b0;
          frame_timeout_d = 1'b0;
        end else begin
          count_d = count_sat;
          ovf_d   = ovf_q | sat_hit;
          cyc_d   = cyc_inc;
        end
      end
      CLOSE: begin
        hist_load      = 1'b1;
        keypoint_num_d = hist_avg;
        num_valid_d    = 1'b1;
        state_d        = UPDATE;
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == COUNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      count_q         <= '0;
      cyc_q           <= '0;
      ovf_q           <= 1'b0;
      keypoint_num_q  <= INIT_V;
      keypoint_raw_q  <= '0;
      num_valid_q     <= 1'b0;
      kp_overflow_q   <= 1'b0;
      frame_timeout_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      cyc_q           <= cyc_d;
      ovf_q           <= ovf_d;
      keypoint_num_q  <= keypoint_num_d;
      keypoint_raw_q  <= keypoint_raw_d;
      num_valid_q     <= num_valid_d;
      kp_overflow_q   <= kp_overflow_d;
      frame_timeout_q <= frame_timeout_d;
      busy_q          <= busy_d;
    end
  end

  assign keypoint_num  = keypoint_num_q;
  assign keypoint_raw  = keypoint_raw_q;
  assign num_valid     = num_valid_q;
  assign kp_overflow   = kp_overflow_q;
  assign frame_timeout = frame_timeout_q;
  assign busy          = busy_q;

endmodule
